capp_search_ctrl: RTL and testbench
===================================

Name: capp_search_ctrl

Overview:
Search and response controller that drives the associative cell array's per-bit mismatch-line pairs from a comparand and mask. It waits for the array to settle, then samples the per-word mismatch outputs. It then streams out each responding (matching) word index, lowest first, over a valid/ready handshake. It sits between the sequencer and the cell array and is the only driver of the array's mismatch lines.

Parameters:
WORDS, 100, number of words in the cell array (match/mismatch vector width)
WIDTH, 32, bits per word; mismatch bus is 2*WIDTH
SETTLE_CYCLES, 2, cycles the lines are held before sampling (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  search request; accepted only in IDLE
comparand  in  WIDTH  search key, latched on accepted start
mask  in  WIDTH  1 = compare this bit, 0 = don't care; latched on start
busy  out  1  high in every state except IDLE
mismatch_lines  out  2*WIDTH  to array; pair {2j+1, 2j} for bit j
match_lines  in  WORDS  from array; 1 = word mismatched, 0 = word responds
resp_valid  out  1  resp_index is valid
resp_ready  in  1  consumer accepts resp_index
resp_index  out  IDX_W  responding word index, IDX_W = $clog2(WORDS)
resp_last  out  1  qualifies final responder while resp_valid
done  out  1  one-cycle pulse at end of search
resp_count  out  IDX_W+1  responder count (only with CAPP_RESP_COUNT_EN)

Behaviour:
- Reset (async, rst_n=0): state IDLE. mismatch_lines=0, busy=0, resp_valid=0, resp_index=0, resp_last=0, done=0, resp_count=0. Internal responder vector cleared. Effective immediately, including mid-search.
- Line encoding, registered: for bit j with mask[j]=1:
  - comparand[j]=1 -> line[2j]=1, line[2j+1]=0 (flags stored 0)
  - comparand[j]=0 -> line[2j+1]=1, line[2j]=0 (flags stored 1)
  - mask[j]=0 -> both 0.
- States:
  - IDLE: lines 0. start=1 -> latch comparand/mask, load lines, settle counter = SETTLE_CYCLES-1 -> SETTLE.
  - SETTLE: lines held; counter decrements each cycle; at 0 -> CAPTURE.
  - CAPTURE (1 cycle): resp_vec <= ~match_lines; resp_count <= popcount(~match_lines); lines return to 0 on next edge. If ~match_lines==0 -> DONE, else -> RESOLVE.
  - RESOLVE: resp_valid=1; resp_index = lowest set bit of resp_vec; resp_last=1 iff exactly one bit set. On resp_valid&resp_ready: clear that bit; next index presented the following cycle (one index per cycle under continuous ready). Handshake with resp_last -> DONE.
  - DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
- Latency: start to first resp_valid = SETTLE_CYCLES+2 cycles. start to done with zero responders = SETTLE_CYCLES+2.
- resp_index/resp_last stable while resp_valid & !resp_ready. resp_valid never drops without a handshake except on reset.
- start while busy ignored; no queuing. start in the same cycle as done: ignored (state is DONE, not IDLE).
- match_lines changes after CAPTURE have no effect.
- resp_count holds its value until the next CAPTURE.

Optional Feature:
CAPP_RESP_COUNT_EN: defined -> resp_count port and popcount logic present, loaded in CAPTURE. Undefined -> port and popcount logic absent; all other behaviour identical.

Decomposition:
- Package capp_pkg: CAPP_WORDS=100, CAPP_WIDTH=32, CAPP_IDX_W, state enum typedef (IDLE, SETTLE, CAPTURE, RESOLVE, DONE).
- Sub-module capp_prio_enc: combinational lowest-set-bit finder over WORDS bits; outputs index, any, and onehot-is-single flag.

Test Plan:
- Bench cell model holds words 0..4 = 456, 457, 1000, 1000, 457 and words 5..99 = 0. start, comparand=457, mask=0xFFFFFFFF, ready=1 -> resp_index 1 then 4; resp_last on 4; resp_count=2; done 1 cycle after index 4.
- comparand=456, mask=0xFFFFFFFE -> indices 0, 1, 4; resp_count=3. Check mismatch_lines[1:0]=00 during SETTLE.
- comparand=0xDEADBEEF, full mask -> no resp_valid; done at start+SETTLE_CYCLES+2; resp_count=0.
- comparand=1000, resp_ready low for 3 cycles in RESOLVE -> resp_index=2 held stable; after ready rises, index 3 with resp_last.
- comparand=0, full mask -> 95 indices 5..99 in order; start pulsed mid-RESOLVE is ignored; resp_count=95.
- rst_n asserted mid-RESOLVE -> all outputs 0 immediately; a fresh start after release works normally.

Source files
------------

// File: rtl/capp_pkg.sv
// Shared constants and state encoding for the CAPP search/response controller.
package capp_pkg;

  localparam int CAPP_WORDS = 100;
  localparam int CAPP_WIDTH = 32;
  localparam int CAPP_IDX_W = $clog2(CAPP_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    RESOLVE,
    DONE
  } capp_state_e;

endpackage

// File: rtl/capp_search_ctrl_if.sv
// Sequencer/consumer-facing bus of capp_search_ctrl.
// resp_count exists only when CAPP_RESP_COUNT_EN is defined.
interface capp_search_ctrl_if
  import capp_pkg::*;
#(
  parameter int WIDTH = CAPP_WIDTH,
  parameter int IDX_W = CAPP_IDX_W
);

  logic             start;
  logic [WIDTH-1:0] comparand;
  logic [WIDTH-1:0] mask;
  logic             busy;
  logic             done;
  logic             resp_valid;
  logic             resp_ready;
  logic [IDX_W-1:0] resp_index;
  logic             resp_last;
`ifdef CAPP_RESP_COUNT_EN
  logic [IDX_W:0]   resp_count;
`endif

  modport master (
    output start, comparand, mask, resp_ready,
`ifdef CAPP_RESP_COUNT_EN
    input  resp_count,
`endif
    input  busy, done, resp_valid, resp_index, resp_last
  );

  modport slave (
    input  start, comparand, mask, resp_ready,
`ifdef CAPP_RESP_COUNT_EN
    output resp_count,
`endif
    output busy, done, resp_valid, resp_index, resp_last
  );

endinterface

// File: rtl/capp_prio_enc.sv
// Combinational lowest-set-bit finder over the responder vector.
module capp_prio_enc
  import capp_pkg::*;
#(
  parameter int WORDS = CAPP_WORDS,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic [WORDS-1:0] vec,
  output logic [IDX_W-1:0] index,
  output logic             any,
  output logic             single
);

  // Scanning downwards lets the lowest set bit win.
  always_comb begin
    index = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (vec[i]) index = IDX_W'(i);
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - WORDS'(1))) == '0);

endmodule

// File: rtl/capp_search_ctrl.sv
// Drives the array mismatch lines, captures responders, and streams their indices.
// Optional: define CAPP_RESP_COUNT_EN to add the resp_count popcount output.
module capp_search_ctrl
  import capp_pkg::*;
#(
  parameter int WORDS         = CAPP_WORDS,
  parameter int WIDTH         = CAPP_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  capp_search_ctrl_if.slave    bus,
  output logic [2*WIDTH-1:0]   mismatch_lines,
  input  logic [WORDS-1:0]     match_lines
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  capp_state_e        state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] lines_q, lines_d;
  logic [WORDS-1:0]   resp_vec_q, resp_vec_d;
  logic [2*WIDTH-1:0] enc_lines;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;
  logic               enc_single;

  capp_prio_enc #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .vec    (resp_vec_q),
    .index  (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  // Line 2j flags words storing 0, line 2j+1 flags words storing 1.
  always_comb begin
    enc_lines = '0;
    for (int j = 0; j < WIDTH; j++) begin
      enc_lines[2*j]   = bus.mask[j] &  bus.comparand[j];
      enc_lines[2*j+1] = bus.mask[j] & ~bus.comparand[j];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lines_d    = lines_q;
    resp_vec_d = resp_vec_q;
    case (state_q)
      IDLE: begin
        lines_d = '0;
        if (bus.start) begin
          lines_d = enc_lines;
          cnt_d   = SETTLE_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CAPTURE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
        lines_d    = '0;
        resp_vec_d = ~match_lines;
        state_d    = (&match_lines) ? DONE : RESOLVE;
      end
      RESOLVE: begin
        if (bus.resp_ready && enc_any) begin
          for (int i = 0; i < WORDS; i++) begin
            if (IDX_W'(i) == enc_idx) resp_vec_d[i] = 1'b0;
          end
          if (enc_single) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lines_q    <= '0;
      resp_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lines_q    <= lines_d;
      resp_vec_q <= resp_vec_d;
    end
  end

  assign mismatch_lines = lines_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.resp_valid = (state_q == RESOLVE) && enc_any;
  assign bus.resp_index = bus.resp_valid ? enc_idx : '0;
  assign bus.resp_last  = bus.resp_valid && enc_single;

`ifdef CAPP_RESP_COUNT_EN
  logic [IDX_W:0] count_q, count_d;

  // Count is loaded only in CAPTURE and otherwise holds for the consumer.
  always_comb begin
    count_d = count_q;
    if (state_q == CAPTURE) begin
      count_d = '0;
      for (int i = 0; i < WORDS; i++) begin
        count_d = count_d + (IDX_W+1)'(!match_lines[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign bus.resp_count = count_q;
`endif

endmodule

// File: tb/tb_capp_search_ctrl.sv
// Directed bench for capp_search_ctrl with a behavioural cell-array model.
module tb_capp_search_ctrl;
  import capp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  capp_search_ctrl_if bus ();
  logic [2*CAPP_WIDTH-1:0] mismatch_lines;
  logic [CAPP_WORDS-1:0]   match_lines;

  capp_search_ctrl #(
    .WORDS         (CAPP_WORDS),
    .WIDTH         (CAPP_WIDTH),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .mismatch_lines (mismatch_lines),
    .match_lines    (match_lines)
  );

  logic [CAPP_WIDTH-1:0] cells [CAPP_WORDS];

  // Cell array model: a word mismatches if any driven line disagrees with its stored bit.
  always_comb begin
    for (int w = 0; w < CAPP_WORDS; w++) begin
      match_lines[w] = 1'b0;
      for (int j = 0; j < CAPP_WIDTH; j++) begin
        if ((mismatch_lines[2*j] && !cells[w][j]) || (mismatch_lines[2*j+1] && cells[w][j]))
          match_lines[w] = 1'b1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int gotIdx[$];
  int gotLast[$];
  int stallIdx[$];
  int firstValid;
  int doneAt;
  logic [3:0] settleLines;
  logic       settleBusy;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_lines"}, 64'(mismatch_lines), 64'd0);
    checkOutput({tag, "_busy"},  64'(bus.busy),       64'd0);
    checkOutput({tag, "_valid"}, 64'(bus.resp_valid), 64'd0);
    checkOutput({tag, "_index"}, 64'(bus.resp_index), 64'd0);
    checkOutput({tag, "_last"},  64'(bus.resp_last),  64'd0);
    checkOutput({tag, "_done"},  64'(bus.done),       64'd0);
`ifdef CAPP_RESP_COUNT_EN
    checkOutput({tag, "_count"}, 64'(bus.resp_count), 64'd0);
`endif
  endtask

  task automatic applyStimulus(input logic [31:0] comp, input logic [31:0] msk);
    @(negedge clk);
    bus.comparand = comp;
    bus.mask      = msk;
    bus.start     = 1'b1;
  endtask

  // Cycle 0 is the cycle start is high; each loop pass samples cycle N at its falling edge.
  task automatic collectResponses(input int readyFrom, input int pulseAt, input int maxCycles);
    int cycles = 0;
    gotIdx.delete();
    gotLast.delete();
    stallIdx.delete();
    firstValid = -1;
    doneAt     = -1;
    while (doneAt < 0 && cycles < maxCycles) begin
      @(negedge clk);
      cycles++;
      bus.start      = (cycles == pulseAt);
      bus.resp_ready = (cycles >= readyFrom);
      if (cycles == 1) begin
        settleLines = mismatch_lines[3:0];
        settleBusy  = bus.busy;
      end
      if (bus.resp_valid) begin
        if (firstValid < 0) firstValid = cycles;
        if (bus.resp_ready) begin
          gotIdx.push_back(int'(bus.resp_index));
          gotLast.push_back(int'(bus.resp_last));
        end else begin
          stallIdx.push_back(int'(bus.resp_index) + (bus.resp_last ? 1000 : 0));
        end
      end
      if (bus.done) doneAt = cycles;
    end
    bus.start      = 1'b0;
    bus.resp_ready = 1'b1;
    if (doneAt < 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL timeout: done not seen within %0d cycles", maxCycles);
    end
  endtask

  initial begin
    for (int w = 0; w < CAPP_WORDS; w++) cells[w] = '0;
    cells[0] = 32'd456;
    cells[1] = 32'd457;
    cells[2] = 32'd1000;
    cells[3] = 32'd1000;
    cells[4] = 32'd457;

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.comparand  = '0;
    bus.mask       = '0;
    bus.resp_ready = 1'b1;
    #12;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkReset("idle");

    $display("[TB] search 457 full mask");
    applyStimulus(32'd457, 32'hFFFF_FFFF);
    collectResponses(0, -1, 50);
    checkOutput("t1_settle_lines", 64'(settleLines), 64'b1001);
    checkOutput("t1_settle_busy",  64'(settleBusy),  64'd1);
    checkOutput("t1_n",            64'(gotIdx.size()), 64'd2);
    if (gotIdx.size() == 2) begin
      checkOutput("t1_idx0",  64'(gotIdx[0]),  64'd1);
      checkOutput("t1_last0", 64'(gotLast[0]), 64'd0);
      checkOutput("t1_idx1",  64'(gotIdx[1]),  64'd4);
      checkOutput("t1_last1", 64'(gotLast[1]), 64'd1);
    end
    checkOutput("t1_first_valid", 64'(firstValid), 64'd4);
    checkOutput("t1_done_at",     64'(doneAt),     64'd6);
`ifdef CAPP_RESP_COUNT_EN
    checkOutput("t1_count", 64'(bus.resp_count), 64'd2);
`endif

    $display("[TB] search 456 with bit0 masked");
    applyStimulus(32'd456, 32'hFFFF_FFFE);
    collectResponses(0, -1, 50);
    checkOutput("t2_settle_lines", 64'(settleLines), 64'b1000);
    checkOutput("t2_n", 64'(gotIdx.size()), 64'd3);
    if (gotIdx.size() == 3) begin
      checkOutput("t2_idx0",  64'(gotIdx[0]),  64'd0);
      checkOutput("t2_idx1",  64'(gotIdx[1]),  64'd1);
      checkOutput("t2_idx2",  64'(gotIdx[2]),  64'd4);
      checkOutput("t2_last1", 64'(gotLast[1]), 64'd0);
      checkOutput("t2_last2", 64'(gotLast[2]), 64'd1);
    end
    checkOutput("t2_done_at", 64'(doneAt), 64'd7);
`ifdef CAPP_RESP_COUNT_EN
    checkOutput("t2_count", 64'(bus.resp_count), 64'd3);
`endif

    $display("[TB] search with no responders");
    applyStimulus(32'hDEAD_BEEF, 32'hFFFF_FFFF);
    collectResponses(0, -1, 50);
    checkOutput("t3_first_valid", 64'(firstValid), 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("t3_n",           64'(gotIdx.size()), 64'd0);
    checkOutput("t3_done_at",     64'(doneAt), 64'd4);
`ifdef CAPP_RESP_COUNT_EN
    checkOutput("t3_count", 64'(bus.resp_count), 64'd0);
`endif

    $display("[TB] search 1000 with consumer stall");
    applyStimulus(32'd1000, 32'hFFFF_FFFF);
    bus.resp_ready = 1'b0;
    collectResponses(7, -1, 50);
    checkOutput("t4_stall_n", 64'(stallIdx.size()), 64'd3);
    foreach (stallIdx[k]) checkOutput($sformatf("t4_stall_idx%0d", k), 64'(stallIdx[k]), 64'd2);
    checkOutput("t4_n", 64'(gotIdx.size()), 64'd2);
    if (gotIdx.size() == 2) begin
      checkOutput("t4_idx0",  64'(gotIdx[0]),  64'd2);
      checkOutput("t4_last0", 64'(gotLast[0]), 64'd0);
      checkOutput("t4_idx1",  64'(gotIdx[1]),  64'd3);
      checkOutput("t4_last1", 64'(gotLast[1]), 64'd1);
    end
    checkOutput("t4_done_at", 64'(doneAt), 64'd9);

    $display("[TB] search 0 with start pulsed mid-stream");
    applyStimulus(32'd0, 32'hFFFF_FFFF);
    collectResponses(0, 20, 200);
    checkOutput("t5_n", 64'(gotIdx.size()), 64'd95);
    if (gotIdx.size() == 95) begin
      for (int k = 0; k < 95; k++) begin
        checkOutput($sformatf("t5_idx%0d", k),  64'(gotIdx[k]),  64'(k + 5));
        checkOutput($sformatf("t5_last%0d", k), 64'(gotLast[k]), 64'(k == 94));
      end
    end
    checkOutput("t5_done_at", 64'(doneAt), 64'd99);
`ifdef CAPP_RESP_COUNT_EN
    checkOutput("t5_count", 64'(bus.resp_count), 64'd95);
`endif
    @(negedge clk);
    checkOutput("t5_idle_busy", 64'(bus.busy), 64'd0);

    $display("[TB] reset during RESOLVE");
    applyStimulus(32'd457, 32'hFFFF_FFFF);
    bus.resp_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    checkOutput("t6_pre_valid", 64'(bus.resp_valid), 64'd1);
    checkOutput("t6_pre_index", 64'(bus.resp_index), 64'd1);
    #2 rst_n = 1'b0;
    #1 checkReset("t6_reset");
    @(negedge clk);
    rst_n          = 1'b1;
    bus.resp_ready = 1'b1;
    applyStimulus(32'd457, 32'hFFFF_FFFF);
    collectResponses(0, -1, 50);
    checkOutput("t6_n", 64'(gotIdx.size()), 64'd2);
    if (gotIdx.size() == 2) begin
      checkOutput("t6_idx0", 64'(gotIdx[0]), 64'd1);
      checkOutput("t6_idx1", 64'(gotIdx[1]), 64'd4);
    end
    checkOutput("t6_done_at", 64'(doneAt), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
